// File: rtl/mem_burst_initiator.sv
// mem_burst_initiator: turns burst read/write commands into per-beat cycles on a
// single-port memory. Write beats come from a valid/ready stream. Read data
// returns through a credit-protected first-word-fall-through response FIFO.
// Optional feature macro: MEM_BURST_INITIATOR_STATS_EN adds saturating beat counters.
module mem_burst_initiator #(
  parameter int AW        = 10,
  parameter int DW        = 16,
  parameter int READ_LAT  = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [3:0]    req_len,
  input  logic          wd_valid,
  output logic          wd_ready,
  input  logic [DW-1:0] wd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          busy,
  output logic          chip_en,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wr_data,
  input  logic [DW-1:0] rd_data
`ifdef MEM_BURST_INITIATOR_STATS_EN
  ,
  input  logic          stat_clr,
  output logic [15:0]   stat_rd_beats,
  output logic [15:0]   stat_wr_beats
`endif
);

  localparam int PW = $clog2(RSP_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cur_addr;
  logic [3:0]    beats_left;
  logic          last_beat;
  logic          issue_wr, issue_rd;
  logic          credit;
  logic          rd_last_q;
  logic [READ_LAT:1] pipe_vld, pipe_last;
  logic [3:0]    inflight;
  logic [PW:0]   fifo_count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DW:0]   fifo_mem [RSP_DEPTH];
  logic [DW:0]   fifo_head;
  logic          push, pop;

  assign last_beat = (beats_left == 4'd0);

  // Count of read beats issued but not yet written into the FIFO.
  always_comb begin
    inflight = {3'b000, rd_en};
    for (int k = 1; k <= READ_LAT; k++) inflight = inflight + {3'b000, pipe_vld[k]};
  end

  assign credit = (int'(fifo_count) + int'(inflight)) < RSP_DEPTH;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode.
  // NOTE: every output of this block is assigned a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    wd_ready  = 1'b0;
    issue_wr  = 1'b0;
    issue_rd  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) state_nxt = req_write ? WRITE : READ;
      end
      WRITE: begin
        wd_ready = 1'b1;
        issue_wr = wd_valid;
        if (wd_valid && last_beat) state_nxt = IDLE;
      end
      READ: begin
        issue_rd = credit;
        if (credit && last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (inflight == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst address/length tracking: latch on accept, advance per issued beat.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      beats_left <= '0;
    end else if (state == IDLE && req_valid) begin
      cur_addr   <= req_addr;
      beats_left <= req_len;
    end else if (issue_wr || issue_rd) begin
      cur_addr   <= cur_addr + 1'b1;
      beats_left <= beats_left - 1'b1;
    end
  end

  // Registered memory interface; addr and wr_data hold between beats.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      chip_en   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      rd_last_q <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
    end else begin
      chip_en   <= issue_wr | issue_rd;
      wr_en     <= issue_wr;
      rd_en     <= issue_rd;
      rd_last_q <= issue_rd & last_beat;
      if (issue_wr || issue_rd) addr <= cur_addr;
      if (issue_wr) wr_data <= wd_data;
    end
  end

  // Read-latency pipe: a beat in stage k was on rd_en k cycles ago.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[1]  <= rd_en;
      pipe_last[1] <= rd_last_q;
      for (int k = 2; k <= READ_LAT; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_last[k] <= pipe_last[k-1];
      end
    end
  end

  assign push = pipe_vld[READ_LAT];
  assign pop  = rsp_valid & rsp_ready;

  // Response FIFO storage.
  // NOTE: the array has no reset; the pointers and count alone say which entries are valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {pipe_last[READ_LAT], rd_data};
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign fifo_head = fifo_mem[rd_ptr];
  assign rsp_valid = (fifo_count != '0);
  assign rsp_data  = rsp_valid ? fifo_head[DW-1:0] : '0;
  assign rsp_last  = rsp_valid & fifo_head[DW];
  assign busy      = (state != IDLE) || (inflight != 4'd0);

`ifdef MEM_BURST_INITIATOR_STATS_EN
  // Saturating counts of driven memory beats; clear wins over increment.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_beats <= '0;
      stat_wr_beats <= '0;
    end else if (stat_clr) begin
      stat_rd_beats <= '0;
      stat_wr_beats <= '0;
    end else begin
      if (rd_en && stat_rd_beats != 16'hFFFF) stat_rd_beats <= stat_rd_beats + 1'b1;
      if (wr_en && stat_wr_beats != 16'hFFFF) stat_wr_beats <= stat_wr_beats + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Testbench for mem_burst_initiator: directed bursts plus randomized traffic,
// checked against a command-level memory image and expected-beat queues.
// The stats section is compiled only when MEM_BURST_INITIATOR_STATS_EN is defined.
module tb_mem_burst_initiator;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int RL    = 2;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0] rsp_data;
  logic          busy, chip_en, wr_en, rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data;
`ifdef MEM_BURST_INITIATOR_STATS_EN
  logic          stat_clr;
  logic [15:0]   stat_rd_beats, stat_wr_beats;
`endif

  mem_burst_initiator #(.AW(AW), .DW(DW), .READ_LAT(RL), .RSP_DEPTH(DEPTH)) dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .chip_en(chip_en), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
`ifdef MEM_BURST_INITIATOR_STATS_EN
    , .stat_clr(stat_clr), .stat_rd_beats(stat_rd_beats), .stat_wr_beats(stat_wr_beats)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Power-on content of the memory, shared by the device model and the reference image.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    logic [15:0] t;
    t = {6'b0, a} * 16'd40503;
    return t ^ 16'h5A3C;
  endfunction

  // Memory device: synchronous write, READ_LAT-cycle read, junk when not reading.
  logic [DW-1:0] dev_mem [1 << AW];
  bit   [(1 << AW)-1:0] dev_vld;
  logic [DW-1:0] dev_pipe [RL];
  always @(posedge clock) begin
    if (wr_en) begin
      dev_mem[addr] <= wr_data;
      dev_vld[addr] <= 1'b1;
    end
    dev_pipe[0] <= rd_en ? (dev_vld[addr] ? dev_mem[addr] : init_val(addr)) : DW'($urandom);
    for (int k = 1; k < RL; k++) dev_pipe[k] <= dev_pipe[k-1];
  end
  assign rd_data = dev_pipe[RL-1];

  // Reference model: memory image plus expected beat and response queues.
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wbeat_t;
  typedef struct packed { logic [DW-1:0] d; logic l; } rsp_t;
  logic [DW-1:0] ref_mem [1 << AW];
  logic [DW-1:0] wbuf [16];
  wbeat_t        exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  rsp_t          exp_rsp[$];
  int rd_issued = 0, rsp_taken = 0, wr_seen = 0;
  wbeat_t mon_wb;
  rsp_t   mon_rsp;

  // Bus monitor: mid-cycle sampling of strobes, beats and response handshakes.
  always @(negedge clock) begin
    if (rst_n) begin
      check("chip_en_or", chip_en, wr_en | rd_en);
      check("wr_rd_excl", wr_en & rd_en, 0);
      if (wr_en) begin
        wr_seen++;
        if (exp_wr.size() == 0) check("wr_unexpected", 32'(exp_wr.size()), 1);
        else begin
          mon_wb = exp_wr.pop_front();
          check("wr_addr", addr, mon_wb.a);
          check("wr_data", wr_data, mon_wb.d);
        end
      end
      if (rd_en) begin
        rd_issued++;
        if (exp_rd.size() == 0) check("rd_unexpected", 32'(exp_rd.size()), 1);
        else check("rd_addr", addr, exp_rd.pop_front());
        check("rsp_overflow", 32'((rd_issued - rsp_taken) <= DEPTH), 1);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", 32'(exp_rsp.size()), 1);
        else begin
          mon_rsp = exp_rsp.pop_front();
          check("rsp_data", rsp_data, mon_rsp.d);
          check("rsp_last", rsp_last, mon_rsp.l);
        end
        rsp_taken++;
      end
    end
  end

  // Response consumer: random back-pressure unless a stall is forced.
  bit stall_rsp = 1'b0;
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      rsp_ready = stall_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [3:0] len);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = len;
    while (!req_ready && n < 500) begin tick(); n++; end
    check("cmd_accept_timeout", 32'(n < 500), 1);
    tick();
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom); req_len = 4'($urandom);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [3:0] len,
                          input int stall_after, input int stall_n);
    wbeat_t b;
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      b.a = a + AW'(i);
      b.d = wbuf[i];
      ref_mem[b.a] = b.d;
      exp_wr.push_back(b);
    end
    send_cmd(1'b1, a, len);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_after) begin
        wd_valid = 1'b0;
        repeat (stall_n) tick();
      end
      wd_valid = 1'b1;
      wd_data  = wbuf[i];
      n = 0;
      while (!wd_ready && n < 100) begin tick(); n++; end
      check("wd_timeout", 32'(n < 100), 1);
      tick();
    end
    wd_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [3:0] len);
    rsp_t r;
    logic [AW-1:0] ai;
    for (int i = 0; i <= int'(len); i++) begin
      ai  = a + AW'(i);
      r.d = ref_mem[ai];
      r.l = (i == int'(len));
      exp_rd.push_back(ai);
      exp_rsp.push_back(r);
    end
    send_cmd(1'b0, a, len);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_rd.size() != 0 || exp_wr.size() != 0 || busy) && n < 2000) begin
      tick(); n++;
    end
    check("idle_timeout", 32'(n < 2000), 1);
  endtask

  int c_rd, c_rsp, base, base2;
  bit hit;

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wd_valid = 1'b0; wd_data = '0;
`ifdef MEM_BURST_INITIATOR_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(AW'(i));

    // Reset values while rst_n is low, then req_ready after release.
    #3;
    check("rst_ctrl", {req_ready, wd_ready, rsp_valid, rsp_last, busy, chip_en, wr_en, rd_en}, 0);
    check("rst_addr", addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rsp_data", rsp_data, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("req_ready_after_rst", req_ready, 1);

    // Single write then read, with response latency measured from rd_en.
    wbuf[0] = 16'hA5A5;
    do_write(10'h005, 4'd0, -1, 0);
    wait_idle();
    do_read(10'h005, 4'd0);
    c_rd = -1; c_rsp = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (rd_en && c_rd < 0) c_rd = c;
      if (rsp_valid && c_rsp < 0) c_rsp = c;
    end
    check("rd_seen", 32'(c_rd >= 0), 1);
    check("rsp_latency", 32'(c_rsp - c_rd), RL + 1);
    wait_idle();

    // Address wrap at the top of memory.
    for (int i = 0; i < 4; i++) wbuf[i] = DW'(i + 1);
    do_write(10'h3FE, 4'd3, -1, 0);
    wait_idle();
    do_read(10'h3FE, 4'd3);
    wait_idle();

    // Write-data stall after beat 2 of an 8-beat burst.
    for (int i = 0; i < 8; i++) wbuf[i] = DW'($urandom);
    base = wr_seen;
    do_write(10'h100, 4'd7, 2, 3);
    wait_idle();
    check("stall_wr_count", 32'(wr_seen - base), 8);

    // Response back-pressure: no more than DEPTH beats may issue while stalled.
    stall_rsp = 1'b1;
    tick(); tick();
    base  = rd_issued;
    base2 = rsp_taken;
    do_read(10'h100, 4'd15);
    repeat (10) tick();
    check("bp_issued_le_depth", 32'((rd_issued - base) <= DEPTH), 1);
    check("bp_issued_some", 32'((rd_issued - base) > 0), 1);
    check("bp_rsp_held", rsp_valid, 1);
    stall_rsp = 1'b0;
    wait_idle();
    check("bp_all_delivered", 32'(rsp_taken - base2), 16);

`ifdef MEM_BURST_INITIATOR_STATS_EN
    // Beat counters and synchronous clear.
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    for (int i = 0; i < 3; i++) wbuf[i] = DW'($urandom);
    do_write(10'h040, 4'd2, -1, 0);
    wait_idle();
    do_read(10'h050, 4'd4);
    wait_idle();
    check("stat_wr", stat_wr_beats, 3);
    check("stat_rd", stat_rd_beats, 5);
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    check("stat_wr_clr", stat_wr_beats, 0);
    check("stat_rd_clr", stat_rd_beats, 0);
`endif

    // Randomized back-to-back traffic.
    for (int t = 0; t < 24; t++) begin
      logic [AW-1:0] ra;
      logic [3:0]    rl;
      ra = AW'($urandom);
      rl = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) wbuf[i] = DW'($urandom);
        do_write(ra, rl, $urandom_range(0, 15), $urandom_range(0, 2));
      end else begin
        do_read(ra, rl);
      end
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    // Asynchronous reset during beat 5 of a 16-beat read.
    base = rd_issued;
    hit  = 1'b0;
    do_read(10'h080, 4'd15);
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clock); #1;
      if (rd_issued - base >= 5) hit = 1'b1;
    end
    check("arst_reached_beat5", hit, 1);
    rst_n = 1'b0;
    #1;
    check("arst_strobes", {chip_en, rd_en, wr_en}, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_req_ready", req_ready, 0);
    exp_rd.delete();
    exp_rsp.delete();
    rsp_taken = rd_issued;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("arst_req_ready_rel", req_ready, 1);
    base2 = rsp_taken;
    do_read(10'h080, 4'd0);
    wait_idle();
    check("arst_fresh_read", 32'(rsp_taken - base2), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
